// File: rtl/fwd_hazard_if.sv
// Decode-side bus between the pipeline and fwd_hazard_unit.
// stall_cycles exists only when FWD_PERF_CNT_EN is defined.
interface fwd_hazard_if #(
   parameter int FSEL_W     = 2,
   parameter int IM_INSTLEN = 32
) ();
   logic [IM_INSTLEN-1:0] inst_de;
   logic                  de_valid;
   logic                  mem_valid;
   logic                  flush;
   logic [FSEL_W-1:0]     fwd_a;
   logic [FSEL_W-1:0]     fwd_b;
   logic                  stall;
   logic                  load_err;
`ifdef FWD_PERF_CNT_EN
   logic [31:0]           stall_cycles;

   modport master (
      output inst_de, de_valid, mem_valid, flush,
      input  fwd_a, fwd_b, stall, load_err, stall_cycles
   );
   modport slave (
      input  inst_de, de_valid, mem_valid, flush,
      output fwd_a, fwd_b, stall, load_err, stall_cycles
   );
`else
   modport master (
      output inst_de, de_valid, mem_valid, flush,
      input  fwd_a, fwd_b, stall, load_err
   );
   modport slave (
      input  inst_de, de_valid, mem_valid, flush,
      output fwd_a, fwd_b, stall, load_err
   );
`endif
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding/hazard scoreboard: tracks rd tags of the last NUM_FWD_STAGES instructions,
// selects bypasses, stalls on load-use and pending-load hazards. FWD_PERF_CNT_EN adds stall_cycles.
module fwd_hazard_unit #(
   parameter int NUM_FWD_STAGES = 2,
   parameter int LOAD_TIMEOUT   = 16
) (
   input  logic         clk,
   input  logic         rst,
   fwd_hazard_if.slave  bus
);
   localparam int N      = NUM_FWD_STAGES;
   localparam int FSEL_W = $clog2(N + 1);
   localparam int CNT_W  = $clog2(LOAD_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic             r_v   [1:N];
   logic [4:0]       r_rd  [1:N];
   logic             r_ld  [1:N];
   logic             r_rdy [1:N];
   logic [CNT_W-1:0] r_to_cnt;
   logic             r_load_err;

   logic [6:0] w_op;
   logic [4:0] w_rd, w_rs1, w_rs2;
   logic       w_writes_rd, w_is_load, w_use_rs1, w_use_rs2;
   logic       w_unused_bits;

   assign w_op          = bus.inst_de[6:0];
   assign w_rd          = bus.inst_de[11:7];
   assign w_rs1         = bus.inst_de[19:15];
   assign w_rs2         = bus.inst_de[24:20];
   assign w_unused_bits = ^{bus.inst_de[31:25], bus.inst_de[14:12]};

   assign w_writes_rd = w_op inside {OP_REG, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
   assign w_is_load   = (w_op == OP_LOAD);
   assign w_use_rs1   = !(w_op inside {OP_LUI, OP_AUIPC, OP_JAL});
   assign w_use_rs2   = w_op inside {OP_REG, OP_STORE, OP_BRANCH};

   logic [N:1] w_match_a, w_match_b, w_unrdy_ld;

   genvar gi;
   generate
      for (gi = 1; gi <= N; gi++) begin : g_stage
         assign w_match_a[gi]  = r_v[gi] && (r_rd[gi] != 5'd0) && (r_rd[gi] == w_rs1) && w_use_rs1;
         assign w_match_b[gi]  = r_v[gi] && (r_rd[gi] != 5'd0) && (r_rd[gi] == w_rs2) && w_use_rs2;
         assign w_unrdy_ld[gi] = r_v[gi] && r_ld[gi] && !r_rdy[gi];
      end
   endgenerate

   logic [FSEL_W-1:0] w_sel_a, w_sel_b, w_cmp_idx, w_tgt;
   logic              w_wait_a, w_wait_b;

   // Descending scan leaves the youngest match; ascending scan leaves the oldest unready load.
   always_comb begin
      w_sel_a   = '0;
      w_sel_b   = '0;
      w_wait_a  = 1'b0;
      w_wait_b  = 1'b0;
      w_cmp_idx = '0;
      for (int k = N; k >= 1; k--) begin
         if (w_match_a[k]) begin
            w_sel_a  = FSEL_W'(k);
            w_wait_a = !r_rdy[k];
         end
         if (w_match_b[k]) begin
            w_sel_b  = FSEL_W'(k);
            w_wait_b = !r_rdy[k];
         end
      end
      for (int k = 1; k <= N; k++) begin
         if (w_unrdy_ld[k]) w_cmp_idx = FSEL_W'(k);
      end
   end

   logic w_cmp_any, w_done, w_lu, w_hold, w_stall, w_shift, w_push_v, w_force, w_set_rdy;

   assign w_cmp_any = |w_unrdy_ld;
   assign w_done    = bus.mem_valid && w_cmp_any;
   assign w_lu      = (w_wait_a && !(w_done && (w_cmp_idx == w_sel_a))) ||
                      (w_wait_b && !(w_done && (w_cmp_idx == w_sel_b)));
   assign w_hold    = w_unrdy_ld[N] && !bus.mem_valid;
   assign w_stall   = (w_lu || w_hold) && !bus.flush;
   assign w_shift   = !w_hold;
   assign w_push_v  = bus.de_valid && w_writes_rd && !w_lu;
   assign w_force   = w_stall && (r_to_cnt == CNT_LAST);
   assign w_set_rdy = (w_done || w_force) && w_cmp_any;
   // Completed load moves with the shift; an index past N means it retires this edge.
   assign w_tgt     = w_shift ? (w_cmp_idx + FSEL_W'(1)) : w_cmp_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= N; k++) begin
            r_v[k]   <= 1'b0;
            r_rd[k]  <= 5'd0;
            r_ld[k]  <= 1'b0;
            r_rdy[k] <= 1'b0;
         end
         r_to_cnt   <= '0;
         r_load_err <= 1'b0;
      end else if (bus.flush) begin
         for (int k = 1; k <= N; k++) r_v[k] <= 1'b0;
         r_to_cnt <= '0;
      end else begin
         if (w_shift) begin
            r_v[1]   <= w_push_v;
            r_rd[1]  <= w_rd;
            r_ld[1]  <= w_is_load;
            r_rdy[1] <= !w_is_load;
            for (int k = 2; k <= N; k++) begin
               r_v[k]   <= r_v[k-1];
               r_rd[k]  <= r_rd[k-1];
               r_ld[k]  <= r_ld[k-1];
               r_rdy[k] <= r_rdy[k-1];
            end
         end
         if (w_set_rdy) begin
            for (int k = 1; k <= N; k++) begin
               if (FSEL_W'(k) == w_tgt) r_rdy[k] <= 1'b1;
            end
         end
         if (!w_stall || w_force) r_to_cnt <= '0;
         else                     r_to_cnt <= r_to_cnt + 1'b1;
         if (w_force) r_load_err <= 1'b1;
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk) begin
      if (rst)          r_stall_cycles <= 32'd0;
      else if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign bus.stall_cycles = r_stall_cycles;
`endif

   assign bus.fwd_a    = w_sel_a;
   assign bus.fwd_b    = w_sel_b;
   assign bus.stall    = w_stall;
   assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a 2-stage/16-timeout instance and a 1-stage instance
// share the same stimulus; each scenario task checks the instance it targets.
module tb_fwd_hazard_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst = 32'd0;
   logic        de_valid = 1'b0, mem_valid = 1'b0, flush = 1'b0;
   int          n_vec = 0, n_err = 0;

   fwd_hazard_if #(.FSEL_W(2)) d_if ();
   fwd_hazard_if #(.FSEL_W(1)) h_if ();

   assign d_if.inst_de = inst;  assign d_if.de_valid = de_valid;
   assign d_if.mem_valid = mem_valid;  assign d_if.flush = flush;
   assign h_if.inst_de = inst;  assign h_if.de_valid = de_valid;
   assign h_if.mem_valid = mem_valid;  assign h_if.flush = flush;

   fwd_hazard_unit #(.NUM_FWD_STAGES(2), .LOAD_TIMEOUT(16)) u_d (.clk(clk), .rst(rst), .bus(d_if.slave));
   fwd_hazard_unit #(.NUM_FWD_STAGES(1), .LOAD_TIMEOUT(16)) u_h (.clk(clk), .rst(rst), .bus(h_if.slave));

   always #5 clk = ~clk;

   function automatic logic [31:0] f_add(input logic [4:0] rd, rs1, rs2);
      return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] f_sub(input logic [4:0] rd, rs1, rs2);
      return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] f_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] f_lw(input logic [4:0] rd, rs1);
      return {12'd0, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] f_lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, 7'b0110111};
   endfunction

   // One transaction: inputs change just after the edge, outputs are sampled on the falling edge.
   task automatic drive(input logic [31:0] i, input logic dv, mv, fl, rs);
      @(posedge clk); #1;
      inst = i; de_valid = dv; mem_valid = mv; flush = fl; rst = rs;
      @(negedge clk);
      $display("t=%0t inst=%h dv=%0b mv=%0b fl=%0b rst=%0b | d: fwd_a=%0d fwd_b=%0d stall=%0b err=%0b | h: fwd_a=%0d stall=%0b",
               $time, i, dv, mv, fl, rs, d_if.fwd_a, d_if.fwd_b, d_if.stall, d_if.load_err, h_if.fwd_a, h_if.stall);
   endtask

   task automatic do_reset();
      drive(32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      drive(f_add(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 1'b1);
      n_vec++; if (d_if.fwd_a !== 2'd0) begin n_err++; $display("FAIL reset_fwd_a got=%0d want=0", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd0) begin n_err++; $display("FAIL reset_fwd_b got=%0d want=0", d_if.fwd_b); end
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%0b want=0", d_if.stall); end
      n_vec++; if (d_if.load_err !== 1'b0) begin n_err++; $display("FAIL reset_load_err got=%0b want=0", d_if.load_err); end
      n_vec++; if (h_if.stall !== 1'b0) begin n_err++; $display("FAIL reset_h_stall got=%0b want=0", h_if.stall); end
      n_vec++; if (h_if.load_err !== 1'b0) begin n_err++; $display("FAIL reset_h_load_err got=%0b want=0", h_if.load_err); end
`ifdef FWD_PERF_CNT_EN
      n_vec++; if (d_if.stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall_cycles got=%0d want=0", d_if.stall_cycles); end
`endif
   endtask

   task automatic test_alu_chain();
      do_reset();
      drive(f_addi(5'd5, 5'd0, 12'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd0) begin n_err++; $display("FAIL alu_addi_fwd_a got=%0d want=0", d_if.fwd_a); end
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL alu_addi_stall got=%0b want=0", d_if.stall); end
      drive(f_add(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd1) begin n_err++; $display("FAIL alu_add_fwd_a got=%0d want=1", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd1) begin n_err++; $display("FAIL alu_add_fwd_b got=%0d want=1", d_if.fwd_b); end
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL alu_add_stall got=%0b want=0", d_if.stall); end
      drive(f_sub(5'd7, 5'd5, 5'd6), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd2) begin n_err++; $display("FAIL alu_sub_fwd_a got=%0d want=2", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd1) begin n_err++; $display("FAIL alu_sub_fwd_b got=%0d want=1", d_if.fwd_b); end
      drive(f_add(5'd1, 5'd7, 5'd5), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd1) begin n_err++; $display("FAIL alu_age_fwd_a got=%0d want=1", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd0) begin n_err++; $display("FAIL alu_age_fwd_b got=%0d want=0", d_if.fwd_b); end
      // de_valid low: the addi writing x2 becomes a bubble
      drive(f_addi(5'd2, 5'd0, 12'd1), 1'b0, 1'b0, 1'b0, 1'b0);
      drive(f_add(5'd3, 5'd2, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd0) begin n_err++; $display("FAIL alu_bubble_fwd_a got=%0d want=0", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd2) begin n_err++; $display("FAIL alu_bubble_fwd_b got=%0d want=2", d_if.fwd_b); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(f_lw(5'd8, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL lu_lw_stall got=%0b want=0", d_if.stall); end
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b1) begin n_err++; $display("FAIL lu_c1_stall got=%0b want=1", d_if.stall); end
      n_vec++; if (d_if.fwd_a !== 2'd1) begin n_err++; $display("FAIL lu_c1_fwd_a got=%0d want=1", d_if.fwd_a); end
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b1) begin n_err++; $display("FAIL lu_c2_stall got=%0b want=1", d_if.stall); end
      n_vec++; if (d_if.fwd_a !== 2'd2) begin n_err++; $display("FAIL lu_c2_fwd_a got=%0d want=2", d_if.fwd_a); end
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b1) begin n_err++; $display("FAIL lu_c3_stall got=%0b want=1", d_if.stall); end
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL lu_ret_stall got=%0b want=0", d_if.stall); end
      n_vec++; if (d_if.fwd_a !== 2'd2) begin n_err++; $display("FAIL lu_ret_fwd_a got=%0d want=2", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd0) begin n_err++; $display("FAIL lu_ret_fwd_b got=%0d want=0", d_if.fwd_b); end
      drive(f_add(5'd10, 5'd9, 5'd8), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd1) begin n_err++; $display("FAIL lu_next_fwd_a got=%0d want=1", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd0) begin n_err++; $display("FAIL lu_next_fwd_b got=%0d want=0", d_if.fwd_b); end
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL lu_next_stall got=%0b want=0", d_if.stall); end
   endtask

   task automatic test_zero_bubble();
      do_reset();
      drive(f_lw(5'd8, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL zb_stall got=%0b want=0", d_if.stall); end
      n_vec++; if (d_if.fwd_a !== 2'd1) begin n_err++; $display("FAIL zb_fwd_a got=%0d want=1", d_if.fwd_a); end
      // completed load has moved to stage 2 and must stay ready there
      drive(f_add(5'd10, 5'd8, 5'd9), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd2) begin n_err++; $display("FAIL zb_next_fwd_a got=%0d want=2", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd1) begin n_err++; $display("FAIL zb_next_fwd_b got=%0d want=1", d_if.fwd_b); end
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL zb_next_stall got=%0b want=0", d_if.stall); end
   endtask

   task automatic test_x0_lui();
      do_reset();
      drive(f_lw(5'd0, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(f_add(5'd3, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd0) begin n_err++; $display("FAIL x0_fwd_a got=%0d want=0", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd0) begin n_err++; $display("FAIL x0_fwd_b got=%0d want=0", d_if.fwd_b); end
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL x0_stall got=%0b want=0", d_if.stall); end
      drive(f_lw(5'd4, 5'd2), 1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL x0_lw4_stall got=%0b want=0", d_if.stall); end
      // imm 0x20 puts 4 in the rs1 field, aliasing x4
      drive(f_lui(5'd4, 20'h00020), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL lui_stall got=%0b want=0", d_if.stall); end
      n_vec++; if (d_if.fwd_a !== 2'd0) begin n_err++; $display("FAIL lui_fwd_a got=%0d want=0", d_if.fwd_a); end
      drive(f_add(5'd5, 5'd4, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd1) begin n_err++; $display("FAIL lui_use_fwd_a got=%0d want=1", d_if.fwd_a); end
      n_vec++; if (d_if.stall !== 1'b1) begin n_err++; $display("FAIL lui_use_hold got=%0b want=1", d_if.stall); end
      drive(f_add(5'd5, 5'd4, 5'd0), 1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL lui_use_rel got=%0b want=0", d_if.stall); end
   endtask

   task automatic test_struct_hold();
      do_reset();
      drive(f_lw(5'd2, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (h_if.stall !== 1'b0) begin n_err++; $display("FAIL sh_lw_stall got=%0b want=0", h_if.stall); end
      drive(f_addi(5'd3, 5'd0, 12'd5), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (h_if.stall !== 1'b1) begin n_err++; $display("FAIL sh_c1_stall got=%0b want=1", h_if.stall); end
      n_vec++; if (h_if.fwd_a !== 1'b0) begin n_err++; $display("FAIL sh_c1_fwd_a got=%0d want=0", h_if.fwd_a); end
      drive(f_addi(5'd3, 5'd0, 12'd5), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (h_if.stall !== 1'b1) begin n_err++; $display("FAIL sh_c2_stall got=%0b want=1", h_if.stall); end
      drive(f_addi(5'd3, 5'd0, 12'd5), 1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++; if (h_if.stall !== 1'b0) begin n_err++; $display("FAIL sh_rel_stall got=%0b want=0", h_if.stall); end
      drive(f_add(5'd4, 5'd3, 5'd2), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (h_if.fwd_a !== 1'b1) begin n_err++; $display("FAIL sh_next_fwd_a got=%0d want=1", h_if.fwd_a); end
      n_vec++; if (h_if.fwd_b !== 1'b0) begin n_err++; $display("FAIL sh_next_fwd_b got=%0d want=0", h_if.fwd_b); end
      n_vec++; if (h_if.stall !== 1'b0) begin n_err++; $display("FAIL sh_next_stall got=%0b want=0", h_if.stall); end
   endtask

   task automatic test_timeout();
      int n_stall;
      do_reset();
      drive(f_lw(5'd8, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      n_stall = 0;
      for (int i = 0; i < 40; i++) begin
         drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
         if (d_if.stall !== 1'b1) break;
         n_stall++;
         if (n_stall == 1) begin
            n_vec++; if (d_if.load_err !== 1'b0) begin n_err++; $display("FAIL to_early_err got=%0b want=0", d_if.load_err); end
         end
      end
      n_vec++; if (n_stall != 16) begin n_err++; $display("FAIL to_stall_len got=%0d want=16", n_stall); end
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL to_after_stall got=%0b want=0", d_if.stall); end
      n_vec++; if (d_if.load_err !== 1'b1) begin n_err++; $display("FAIL to_load_err got=%0b want=1", d_if.load_err); end
      n_vec++; if (d_if.fwd_a !== 2'd2) begin n_err++; $display("FAIL to_fwd_a got=%0d want=2", d_if.fwd_a); end
`ifdef FWD_PERF_CNT_EN
      n_vec++; if (d_if.stall_cycles !== 32'd16) begin n_err++; $display("FAIL to_stall_cycles got=%0d want=16", d_if.stall_cycles); end
`endif
      drive(f_addi(5'd1, 5'd0, 12'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.load_err !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%0b want=1", d_if.load_err); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(f_lw(5'd8, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b1) begin n_err++; $display("FAIL fl_pre_stall got=%0b want=1", d_if.stall); end
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b1, 1'b0);
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got=%0b want=0", d_if.stall); end
      drive(f_add(5'd10, 5'd9, 5'd8), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.fwd_a !== 2'd0) begin n_err++; $display("FAIL fl_post_fwd_a got=%0d want=0", d_if.fwd_a); end
      n_vec++; if (d_if.fwd_b !== 2'd0) begin n_err++; $display("FAIL fl_post_fwd_b got=%0d want=0", d_if.fwd_b); end
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL fl_post_stall got=%0b want=0", d_if.stall); end
`ifdef FWD_PERF_CNT_EN
      n_vec++; if (d_if.stall_cycles !== 32'd1) begin n_err++; $display("FAIL fl_stall_cycles got=%0d want=1", d_if.stall_cycles); end
`endif
   endtask

   task automatic test_reset_during_stall();
      do_reset();
      drive(f_lw(5'd8, 5'd1), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b1);
      n_vec++; if (d_if.stall !== 1'b1) begin n_err++; $display("FAIL rs_same_cycle_stall got=%0b want=1", d_if.stall); end
      drive(f_add(5'd9, 5'd8, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++; if (d_if.stall !== 1'b0) begin n_err++; $display("FAIL rs_after_stall got=%0b want=0", d_if.stall); end
      n_vec++; if (d_if.fwd_a !== 2'd0) begin n_err++; $display("FAIL rs_after_fwd_a got=%0d want=0", d_if.fwd_a); end
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_load_use();
      test_zero_bubble();
      test_x0_lui();
      test_struct_hold();
      test_timeout();
      test_flush();
      test_reset_during_stall();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
